ps2_device_port: RTL and testbench

Device-side PS/2 transceiver: the opposite end of the host interface that drives the mouse. It generates the PS/2 clock and transmits bytes to a host, such as mouse packet bytes or the 0xFA acknowledge. It also detects host request-to-send, clocks in the host command byte (for example 0xF4), checks parity and returns the line acknowledge. It serves as the mouse/keyboard emulator for on-board loopback and as the device model in host benches.

---
 rtl/ps2_device_port.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_device_port.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_port.sv
// ps2_device_port: device-side PS/2 transceiver.
// Generates the PS/2 clock, transmits bytes to the host, and receives host
// commands after a request-to-send, returning the line acknowledge.
module ps2_device_port #(
    parameter int unsigned CLK_HALF = 4000
) (
    input  logic       clk,
    input  logic       clr,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam int unsigned   TW       = $clog2(2 * CLK_HALF);
    localparam logic [TW-1:0] HALF_LD  = TW'(CLK_HALF - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(2 * CLK_HALF - 1);
    localparam logic [3:0]    LAST_BIT = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_TX_HI,
        S_TX_LO,
        S_RX_LO,
        S_RX_HI,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [3:0]      bit_q;
    logic [3:0]      bit_nxt;
    logic [10:0]     frame_q;
    logic            retry_q;
    logic            clk_drv_q;
    logic            data_drv_q;
    logic [7:0]      rx_shift_q;
    logic            rx_par_q;
    logic            rx_stop_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            rx_err_q;
    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic [1:0]      sync_ok_q;
    logic            clk_s;
    logic            data_s;
    logic            timer_done;
    logic            rx_par_ok;

    // Open-drain line drivers: only ever pull low or release.
    assign ps2_clk  = clk_drv_q  ? 1'b0 : 1'bz;
    assign ps2_data = data_drv_q ? 1'b0 : 1'bz;

    assign clk_s      = clk_sync_q[1];
    assign data_s     = data_sync_q[1];
    assign timer_done = (timer_q == '0);
    assign bit_nxt    = bit_q + 4'd1;
    assign rx_par_ok  = ^{rx_shift_q, rx_par_q};

    assign busy     = (state_q != S_IDLE);
    assign tx_ready = (state_q == S_IDLE) && clk_s && data_s && !retry_q && sync_ok_q[1];
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

    // Two-flop synchronizers for both lines; sync_ok holds off tx_ready until
    // the synchronizers have seen two real samples after reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            sync_ok_q   <= 2'b00;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            sync_ok_q   <= {sync_ok_q[0], 1'b1};
        end
    end

    // Protocol FSM with registered line drives and receive status.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            retry_q    <= 1'b0;
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_stop_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            if (!timer_done) begin
                timer_q <= timer_q - TW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (!clk_s) begin
                        state_q <= S_INHIBIT;
                        timer_q <= HALF_LD;
                    end else if (retry_q && data_s) begin
                        // Resend the latched frame from its start bit.
                        state_q    <= S_TX_HI;
                        timer_q    <= HALF_LD;
                        bit_q      <= '0;
                        data_drv_q <= 1'b1;
                    end else if (tx_valid && tx_ready) begin
                        frame_q    <= {1'b1, ~^tx_data, tx_data, 1'b0};
                        state_q    <= S_TX_HI;
                        timer_q    <= HALF_LD;
                        bit_q      <= '0;
                        data_drv_q <= 1'b1;
                    end
                end
                S_INHIBIT: begin
                    if (clk_s) begin
                        if (!data_s) begin
                            state_q <= S_RTS;
                            timer_q <= HALF_LD;
                        end else begin
                            state_q <= S_GAP;
                            timer_q <= GAP_LD;
                        end
                    end
                end
                S_RTS: begin
                    if (timer_done) begin
                        state_q   <= S_RX_LO;
                        timer_q   <= HALF_LD;
                        bit_q     <= '0;
                        clk_drv_q <= 1'b1;
                    end
                end
                S_TX_HI: begin
                    if (timer_done) begin
                        if (!clk_s) begin
                            // Host inhibited mid-frame: back off and retry later.
                            clk_drv_q  <= 1'b0;
                            data_drv_q <= 1'b0;
                            retry_q    <= 1'b1;
                            state_q    <= S_INHIBIT;
                            timer_q    <= HALF_LD;
                        end else begin
                            clk_drv_q <= 1'b1;
                            state_q   <= S_TX_LO;
                            timer_q   <= HALF_LD;
                        end
                    end
                end
                S_TX_LO: begin
                    if (timer_done) begin
                        clk_drv_q <= 1'b0;
                        if (bit_q == LAST_BIT) begin
                            data_drv_q <= 1'b0;
                            retry_q    <= 1'b0;
                            state_q    <= S_GAP;
                            timer_q    <= GAP_LD;
                        end else begin
                            bit_q      <= bit_nxt;
                            data_drv_q <= ~frame_q[bit_nxt];
                            state_q    <= S_TX_HI;
                            timer_q    <= HALF_LD;
                        end
                    end
                end
                S_RX_LO: begin
                    if (timer_done) begin
                        clk_drv_q <= 1'b0;
                        state_q   <= S_RX_HI;
                        timer_q   <= HALF_LD;
                    end
                end
                S_RX_HI: begin
                    if (timer_done) begin
                        if (bit_q == LAST_BIT) begin
                            // End of the acknowledge pulse: release data, report.
                            data_drv_q <= 1'b0;
                            state_q    <= S_GAP;
                            timer_q    <= GAP_LD;
                            if (rx_stop_q && rx_par_ok) begin
                                rx_data_q  <= rx_shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                rx_err_q <= 1'b1;
                            end
                        end else begin
                            if (bit_q < 4'd8) begin
                                rx_shift_q <= {data_s, rx_shift_q[7:1]};
                            end else if (bit_q == 4'd8) begin
                                rx_par_q <= data_s;
                            end else begin
                                rx_stop_q  <= data_s;
                                data_drv_q <= data_s;
                            end
                            bit_q     <= bit_nxt;
                            clk_drv_q <= 1'b1;
                            state_q   <= S_RX_LO;
                            timer_q   <= HALF_LD;
                        end
                    end
                end
                S_GAP: begin
                    if (timer_done) begin
                        state_q <= S_IDLE;
                        timer_q <= HALF_LD;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    clk_drv_q  <= 1'b0;
                    data_drv_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_port.sv
// tb_ps2_device_port: directed bench acting as the PS/2 host for ps2_device_port.
module tb_ps2_device_port;

    localparam int unsigned CH = 4;

    logic       clk      = 1'b0;
    logic       clr      = 1'b1;
    logic [7:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;

    logic host_clk_low  = 1'b0;
    logic host_data_low = 1'b0;
    wire  ps2_clk;
    wire  ps2_data;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = host_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = host_data_low ? 1'b0 : 1'bz;

    ps2_device_port #(.CLK_HALF(CH)) dut (
        .clk      (clk),
        .clr      (clr),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          cyc        = 0;
    int          nfall      = 0;
    int          first_fall = 0;
    int          last_fall  = 0;
    int          n_rxv      = 0;
    int          n_rxe      = 0;
    int          n_acc      = 0;
    logic        prev_clk   = 1'b1;
    logic [15:0] fall_bits  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle, sampled at the falling system-clock edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (prev_clk && !ps2_clk) begin
            if (nfall < 16) fall_bits[nfall[3:0]] = ps2_data;
            if (nfall == 0) first_fall = cyc;
            last_fall = cyc;
            nfall++;
        end
        prev_clk = ps2_clk;
        if (rx_valid) n_rxv++;
        if (rx_err) n_rxe++;
        if (tx_ready && tx_valid) n_acc++;
    endtask

    task automatic send_tx(input logic [7:0] b, output int acc_cyc, output int rdy_cyc);
        tx_data  = b;
        tx_valid = 1'b1;
        check("tx_ready_idle", tx_ready, 1);
        step();
        acc_cyc   = cyc;
        tx_valid  = 1'b0;
        nfall     = 0;
        fall_bits = '0;
        rdy_cyc   = -1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx_ready) begin
                rdy_cyc = cyc;
                break;
            end
        end
    endtask

    // Host request-to-send followed by one host frame {stop, parity, byte}.
    task automatic host_frame(input logic [7:0] b, input logic par, input logic stop,
                              input bit with_tx, input int abort_at);
        logic [9:0] bits;
        int         seen;
        bits = {stop, par, b};
        host_clk_low = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (with_tx && i == 1) begin
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                check("rts_same_cycle_ready", tx_ready, 0);
            end
        end
        host_data_low = 1'b1;
        step();
        host_clk_low = 1'b0;
        nfall     = 0;
        fall_bits = '0;
        n_rxv     = 0;
        n_rxe     = 0;
        seen      = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (abort_at != 0 && nfall == abort_at) return;
            if (nfall != seen && nfall <= 10) begin
                host_data_low = ~bits[nfall - 1];
            end
            seen = nfall;
            if (nfall >= 11 && !busy) break;
        end
        host_data_low = 1'b0;
        check("rx_frame_done", (nfall >= 11 && !busy), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc;
        int rdy_cyc;
        int early;

        // Reset state
        repeat (3) step();
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_err", rx_err, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_clk_rel", ps2_clk, 1);
        check("rst_data_rel", ps2_data, 1);
        clr = 1'b0;
        step();
        check("ready_sync_wait", tx_ready, 0);
        step();
        check("ready_after_reset", tx_ready, 1);
        repeat (4) step();

        // Transmit 0xFA
        send_tx(8'hFA, acc_cyc, rdy_cyc);
        check("fa_falls", nfall, 11);
        check("fa_bits", fall_bits[10:0], 11'h7F4);
        check("fa_first_fall", first_fall - acc_cyc, CH);
        check("fa_frame_span", last_fall - first_fall, 20 * CH);
        check("fa_ready_back", rdy_cyc - acc_cyc, 24 * CH);

        // Host sends 0xF4, good parity
        host_frame(8'hF4, 1'b0, 1'b1, 1'b0, 0);
        check("f4_falls", nfall, 11);
        check("f4_ack", fall_bits[10], 0);
        check("f4_rx_valid", n_rxv, 1);
        check("f4_rx_err", n_rxe, 0);
        check("f4_rx_data", rx_data, 8'hF4);

        // Host sends 0xF4 with parity 1
        host_frame(8'hF4, 1'b1, 1'b1, 1'b0, 0);
        check("f4p_ack", fall_bits[10], 0);
        check("f4p_rx_err", n_rxe, 1);
        check("f4p_rx_valid", n_rxv, 0);
        check("f4p_rx_data", rx_data, 8'hF4);

        // Bad parity on a different byte must not overwrite rx_data
        host_frame(8'h12, 1'b0, 1'b1, 1'b0, 0);
        check("b12_rx_err", n_rxe, 1);
        check("b12_rx_data", rx_data, 8'hF4);

        // Host inhibits during bit 4 of 0x55
        repeat (4) step();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        check("inh_tx_ready", tx_ready, 1);
        step();
        tx_valid  = 1'b0;
        nfall     = 0;
        fall_bits = '0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (nfall == 4 && ps2_clk) break;
        end
        check("inh_bit4_driven", ps2_data, 0);
        step();
        host_clk_low = 1'b1;
        repeat (3) step();
        check("inh_data_released", ps2_data, 1);
        check("inh_busy", busy, 1);
        repeat (20) step();
        check("inh_busy_hold", busy, 1);
        check("inh_ready_hold", tx_ready, 0);
        host_clk_low = 1'b0;
        nfall     = 0;
        fall_bits = '0;
        early     = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (tx_ready && nfall < 11) early++;
            if (nfall >= 11 && tx_ready) break;
        end
        check("retx_falls", nfall, 11);
        check("retx_bits", fall_bits[10:0], 11'h6AA);
        check("retx_ready_early", early, 0);

        // Host RTS with tx_valid raised as the bus goes low
        repeat (4) step();
        n_acc = 0;
        host_frame(8'hA7, 1'b0, 1'b1, 1'b1, 0);
        check("rts_rx_valid", n_rxv, 1);
        check("rts_rx_data", rx_data, 8'hA7);
        check("rts_accepts", n_acc, 1);
        check("rts_ready_idle", tx_ready, 1);
        step();
        tx_valid  = 1'b0;
        nfall     = 0;
        fall_bits = '0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx_ready) break;
        end
        check("rts_tx_falls", nfall, 11);
        check("rts_tx_bits", fall_bits[10:0], 11'h678);

        // Reset asserted at RX pulse 6
        repeat (4) step();
        host_frame(8'hF4, 1'b0, 1'b1, 1'b0, 6);
        check("clr_mid_busy", busy, 1);
        host_data_low = 1'b0;
        clr = 1'b1;
        #1;
        check("clr_clk_rel", ps2_clk, 1);
        check("clr_data_rel", ps2_data, 1);
        check("clr_busy", busy, 0);
        check("clr_tx_ready", tx_ready, 0);
        check("clr_rx_data", rx_data, 0);
        n_rxv = 0;
        n_rxe = 0;
        repeat (2) step();
        clr = 1'b0;
        repeat (2) step();
        check("clr_ready_back", tx_ready, 1);
        repeat (40) step();
        check("clr_no_rx_valid", n_rxv, 0);
        check("clr_no_rx_err", n_rxe, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
